bsg_nonce_dispatch: RTL and testbench

Job-side driver for the double-SHA target-check path: accepts a mining job (start nonce, nonce count, target), issues nonces one at a time with the job target through a valid/ready handshake, and retires the in-order 1-bit hit results with a valid/yumi handshake. After the whole range is resolved, it reports the first winning nonce, or reports that no nonce won. It sits between the job controller and the hash core plus target checker.

---
 rtl/bsg_sha_pkg.sv | 16 +
 rtl/bsg_nonce_fifo.sv | 50 +++++
 rtl/bsg_nonce_dispatch.sv | 148 ++++++++++++++
 tb/tb_bsg_nonce_dispatch.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_sha_pkg.sv
// Shared types and width constants for the double-SHA nonce dispatch path.
// Holds the dispatcher state encoding and the default nonce/target/credit sizes.
package bsg_sha_pkg;

    localparam int nonce_width_lp  = 32;
    localparam int target_width_lp = 32;
    localparam int credits_lp      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } dispatch_state_e;

endpackage

// File: rtl/bsg_nonce_fifo.sv
// Small in-order FIFO holding the nonces that are in flight through the hash path.
// Head is read combinationally so a result can pop and record its nonce in one cycle.
module bsg_nonce_fifo
    import bsg_sha_pkg::*;
#(
    parameter int depth_p = credits_lp,
    parameter int width_p = nonce_width_lp
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               empty_o,
    output logic               full_o
);
    localparam int ptr_w = $clog2(depth_p);

    logic [width_p-1:0] mem [0:depth_p-1];
    logic [ptr_w:0]     wr_ptr_reg;
    logic [ptr_w:0]     rd_ptr_reg;
    logic               do_push;
    logic               do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[ptr_w] != rd_ptr_reg[ptr_w]) &&
                     (wr_ptr_reg[ptr_w-1:0] == rd_ptr_reg[ptr_w-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem[rd_ptr_reg[ptr_w-1:0]];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg[ptr_w-1:0]] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_nonce_dispatch.sv
// Issues a job's nonce range to the hash/check path and retires in-order hit results.
// Define BSG_NONCE_DISPATCH_EARLY_STOP_EN to stop issuing after the first retired hit.
module bsg_nonce_dispatch
    import bsg_sha_pkg::*;
#(
    parameter int nonce_width_p  = nonce_width_lp,
    parameter int target_width_p = target_width_lp,
    parameter int credits_p      = credits_lp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      job_v_i,
    output logic                      job_ready_o,
    input  logic [nonce_width_p-1:0]  job_start_i,
    input  logic [nonce_width_p-1:0]  job_count_i,
    input  logic [target_width_p-1:0] job_target_i,
    output logic                      v_o,
    input  logic                      ready_i,
    output logic [nonce_width_p-1:0]  nonce_o,
    output logic [target_width_p-1:0] target_o,
    input  logic                      v_i,
    input  logic                      data_i,
    output logic                      yumi_o,
    output logic                      done_v_o,
    output logic                      found_o,
    output logic [nonce_width_p-1:0]  nonce_found_o,
    input  logic                      done_yumi_i
);
    localparam int cnt_w = $clog2(credits_p) + 1;
    localparam logic [cnt_w-1:0] credits_c = cnt_w'(credits_p);

    dispatch_state_e           state_reg;
    logic [nonce_width_p-1:0]  nonce_reg;
    logic [nonce_width_p-1:0]  count_reg;
    logic [target_width_p-1:0] target_reg;
    logic [nonce_width_p-1:0]  issued_reg;
    logic [nonce_width_p-1:0]  issued_next;
    logic [cnt_w-1:0]          outstanding_reg;
    logic [cnt_w-1:0]          outstanding_next;
    logic                      found_reg;
    logic                      found_next;
    logic [nonce_width_p-1:0]  nonce_found_reg;

    logic                      fire;
    logic                      retire;
    logic                      hit;
    logic                      stop;
    logic                      stop_next;
    logic [nonce_width_p-1:0]  fifo_head;
    logic                      fifo_empty;
    logic                      fifo_full;

`ifdef BSG_NONCE_DISPATCH_EARLY_STOP_EN
    assign stop      = found_reg;
    assign stop_next = found_next;
`else
    assign stop      = 1'b0;
    assign stop_next = 1'b0;
`endif

    assign v_o = (state_reg == ISSUE) && (issued_reg < count_reg) &&
                 (outstanding_reg < credits_c) && !fifo_full && !stop;
    assign fire          = v_o && ready_i;
    // Results with nothing in flight (e.g. left over from before a reset) are dropped.
    assign yumi_o        = v_i;
    assign retire        = v_i && !fifo_empty;
    assign hit           = retire && data_i && !found_reg;
    assign found_next    = found_reg || hit;
    assign issued_next   = issued_reg + nonce_width_p'(fire);

    assign job_ready_o   = (state_reg == IDLE);
    assign done_v_o      = (state_reg == REPORT);
    assign nonce_o       = nonce_reg;
    assign target_o      = target_reg;
    assign found_o       = found_reg;
    assign nonce_found_o = nonce_found_reg;

    always_comb begin
        outstanding_next = outstanding_reg;
        if (fire && !retire) begin
            outstanding_next = outstanding_reg + cnt_w'(1);
        end else if (!fire && retire) begin
            outstanding_next = outstanding_reg - cnt_w'(1);
        end
    end

    bsg_nonce_fifo #(
        .depth_p (credits_p),
        .width_p (nonce_width_p)
    ) fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (fire),
        .data_i  (nonce_reg),
        .pop_i   (retire),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_reg       <= IDLE;
            nonce_reg       <= '0;
            count_reg       <= '0;
            target_reg      <= '0;
            issued_reg      <= '0;
            outstanding_reg <= '0;
            found_reg       <= 1'b0;
            nonce_found_reg <= '0;
        end else begin
            issued_reg      <= issued_next;
            outstanding_reg <= outstanding_next;
            found_reg       <= found_next;
            if (hit)  nonce_found_reg <= fifo_head;
            if (fire) nonce_reg <= nonce_reg + nonce_width_p'(1);

            case (state_reg)
                IDLE: begin
                    if (job_v_i) begin
                        nonce_reg       <= job_start_i;
                        count_reg       <= job_count_i;
                        target_reg      <= job_target_i;
                        issued_reg      <= '0;
                        outstanding_reg <= '0;
                        found_reg       <= 1'b0;
                        nonce_found_reg <= '0;
                        state_reg       <= (job_count_i == '0) ? REPORT : ISSUE;
                    end
                end
                ISSUE: begin
                    // Look at next-cycle counts so a retirement this cycle is not lost a cycle.
                    if ((issued_next == count_reg) || stop_next) begin
                        state_reg <= (outstanding_next == '0) ? REPORT : DRAIN;
                    end
                end
                DRAIN: begin
                    if (outstanding_next == '0) state_reg <= REPORT;
                end
                REPORT: begin
                    if (done_yumi_i) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bsg_nonce_dispatch.sv
// Directed bench for bsg_nonce_dispatch: full range, early stop, credits, wrap, zero count, reset.
// Inputs change at the falling edge; outputs are sampled 1 ns later, before the rising edge.
module tb_bsg_nonce_dispatch;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        job_v_i;
    logic        job_ready_o;
    logic [31:0] job_start_i;
    logic [31:0] job_count_i;
    logic [31:0] job_target_i;
    logic        v_o;
    logic        ready_i;
    logic [31:0] nonce_o;
    logic [31:0] target_o;
    logic        v_i;
    logic        data_i;
    logic        yumi_o;
    logic        done_v_o;
    logic        found_o;
    logic [31:0] nonce_found_o;
    logic        done_yumi_i;

    int checks = 0;
    int errors = 0;

    logic [31:0] fired_nonce [0:63];
    int          fired_cyc   [0:63];

    always #5 clk = ~clk;

    bsg_nonce_dispatch dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .job_v_i       (job_v_i),
        .job_ready_o   (job_ready_o),
        .job_start_i   (job_start_i),
        .job_count_i   (job_count_i),
        .job_target_i  (job_target_i),
        .v_o           (v_o),
        .ready_i       (ready_i),
        .nonce_o       (nonce_o),
        .target_o      (target_o),
        .v_i           (v_i),
        .data_i        (data_i),
        .yumi_o        (yumi_o),
        .done_v_o      (done_v_o),
        .found_o       (found_o),
        .nonce_found_o (nonce_found_o),
        .done_yumi_i   (done_yumi_i)
    );

    task automatic submit(input logic [31:0] start, input logic [31:0] count, input logic [31:0] target);
        @(negedge clk);
        job_v_i      = 1'b1;
        job_start_i  = start;
        job_count_i  = count;
        job_target_i = target;
        ready_i      = 1'b0;
        v_i          = 1'b0;
        data_i       = 1'b0;
        done_yumi_i  = 1'b0;
        #1;
        checks++;
        if (job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL submit_ready: job_ready_o=%b expected 1", job_ready_o);
        end
        $display("job start=%h count=%0d target=%h", start, count, target);
    endtask

    // Drives one job to completion: returns results in order 'lat' cycles after issue
    // (not before cycle 'hold'), flags result i as a hit when hits[i]=1, and watches
    // the issue handshake for credit limits, stall stability and resume-after-retire.
    task automatic run_job(input logic [31:0] target, input int lat, input logic [63:0] hits,
                           input bit toggle, input int hold, input int budget,
                           output int n_fired, output int c_done);
        int          ret_ptr;
        int          out_now;
        int          resume_chk;
        bit          prev_stall;
        logic [31:0] prev_nonce;
        ret_ptr    = 0;
        n_fired    = 0;
        c_done     = -1;
        resume_chk = -1;
        prev_stall = 1'b0;
        prev_nonce = '0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            job_v_i     = (c == 1);
            job_start_i = 32'hDEAD_0000;
            job_count_i = 32'd1;
            ready_i     = toggle ? ((c % 2) == 0) : 1'b1;
            out_now     = n_fired - ret_ptr;
            v_i         = 1'b0;
            data_i      = 1'b0;
            if (ret_ptr < n_fired && c >= fired_cyc[ret_ptr] + lat && c >= hold) begin
                v_i    = 1'b1;
                data_i = hits[ret_ptr];
            end
            #1;
            checks++;
            if (yumi_o !== v_i) begin
                errors++;
                $display("FAIL yumi_follows_v: cycle=%0d yumi_o=%b expected %b", c, yumi_o, v_i);
            end
            if (done_v_o === 1'b1) begin
                c_done = c;
                break;
            end
            if (out_now >= 4) begin
                checks++;
                if (v_o !== 1'b0) begin
                    errors++;
                    $display("FAIL credit_limit: cycle=%0d v_o=%b expected 0 with %0d outstanding", c, v_o, out_now);
                end
            end
            if (prev_stall) begin
                checks++;
                if (v_o !== 1'b1 || nonce_o !== prev_nonce) begin
                    errors++;
                    $display("FAIL stall_hold: cycle=%0d v_o=%b nonce_o=%h expected 1 %h", c, v_o, nonce_o, prev_nonce);
                end
            end
            if (c == resume_chk) begin
                checks++;
                if (v_o !== 1'b1) begin
                    errors++;
                    $display("FAIL resume_after_retire: cycle=%0d v_o=%b expected 1", c, v_o);
                end
            end
            if (v_o === 1'b1 && ready_i) begin
                fired_nonce[n_fired] = nonce_o;
                fired_cyc[n_fired]   = c;
                checks++;
                if (target_o !== target) begin
                    errors++;
                    $display("FAIL target_out: cycle=%0d target_o=%h expected %h", c, target_o, target);
                end
                $display("issue cycle=%0d nonce=%h", c, nonce_o);
                n_fired++;
            end
            prev_stall = (v_o === 1'b1) && !ready_i;
            prev_nonce = nonce_o;
            if (v_i) begin
                if (out_now == 4 && resume_chk < 0) resume_chk = c + 1;
                $display("result cycle=%0d index=%0d hit=%b", c, ret_ptr, data_i);
                ret_ptr++;
            end
        end
        job_v_i = 1'b0;
        ready_i = 1'b0;
        v_i     = 1'b0;
        data_i  = 1'b0;
        checks++;
        if (c_done < 0) begin
            errors++;
            $display("FAIL done_timeout: no done_v_o within %0d cycles", budget);
        end
    endtask

    // Checks the report, holds it one cycle, accepts it and confirms the return to IDLE.
    task automatic drain_report(input logic exp_found, input logic [31:0] exp_nonce);
        checks++;
        if (found_o !== exp_found || nonce_found_o !== exp_nonce) begin
            errors++;
            $display("FAIL report_value: found_o=%b nonce_found_o=%h expected %b %h", found_o, nonce_found_o, exp_found, exp_nonce);
        end
        checks++;
        if (v_o !== 1'b0) begin
            errors++;
            $display("FAIL report_no_issue: v_o=%b expected 0", v_o);
        end
        @(negedge clk);
        done_yumi_i = 1'b1;
        #1;
        checks++;
        if (done_v_o !== 1'b1 || found_o !== exp_found || nonce_found_o !== exp_nonce) begin
            errors++;
            $display("FAIL report_hold: done_v_o=%b found_o=%b nonce_found_o=%h expected 1 %b %h", done_v_o, found_o, nonce_found_o, exp_found, exp_nonce);
        end
        @(negedge clk);
        done_yumi_i = 1'b0;
        #1;
        checks++;
        if (job_ready_o !== 1'b1 || done_v_o !== 1'b0) begin
            errors++;
            $display("FAIL report_to_idle: job_ready_o=%b done_v_o=%b expected 1 0", job_ready_o, done_v_o);
        end
        $display("report found=%b nonce=%h", found_o, nonce_found_o);
    endtask

    task automatic test_reset();
        reset_i      = 1'b0;
        job_v_i      = 1'b0;
        job_start_i  = '0;
        job_count_i  = '0;
        job_target_i = '0;
        ready_i      = 1'b0;
        v_i          = 1'b0;
        data_i       = 1'b0;
        done_yumi_i  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (job_ready_o !== 1'b1 || v_o !== 1'b0 || done_v_o !== 1'b0 || found_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ready=%b v=%b done=%b found=%b expected 1 0 0 0", job_ready_o, v_o, done_v_o, found_o);
        end
        checks++;
        if (nonce_o !== 32'h0 || target_o !== 32'h0 || nonce_found_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: nonce=%h target=%h nonce_found=%h expected 0 0 0", nonce_o, target_o, nonce_found_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        $display("reset released");
    endtask

    task automatic test_full_range();
        int n;
        int cd;
        logic [31:0] exp;
        submit(32'h10, 32'd5, 32'h0F00_0000);
        run_job(32'h0F00_0000, 3, 64'h0, 1'b0, 0, 60, n, cd);
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL full_count: issued=%0d expected 5", n);
        end
        for (int i = 0; i < n && i < 5; i++) begin
            exp = 32'h10 + 32'(i);
            checks++;
            if (fired_nonce[i] !== exp || fired_cyc[i] != i) begin
                errors++;
                $display("FAIL full_seq: idx=%0d nonce=%h cycle=%0d expected %h %0d", i, fired_nonce[i], fired_cyc[i], exp, i);
            end
        end
        checks++;
        if (cd != 8) begin
            errors++;
            $display("FAIL full_done_cycle: done at %0d expected 8", cd);
        end
        drain_report(1'b0, 32'h0);
    endtask

    task automatic test_early_stop();
        int n;
        int cd;
        int exp_n;
        int exp_cd;
        logic [31:0] exp;
`ifdef BSG_NONCE_DISPATCH_EARLY_STOP_EN
        exp_n  = 6;
        exp_cd = 9;
`else
        exp_n  = 16;
        exp_cd = 19;
`endif
        submit(32'h100, 32'd16, 32'h0000_FFFF);
        run_job(32'h0000_FFFF, 3, 64'h4, 1'b0, 0, 60, n, cd);
        checks++;
        if (n != exp_n) begin
            errors++;
            $display("FAIL stop_count: issued=%0d expected %0d", n, exp_n);
        end
        for (int i = 0; i < n && i < 16; i++) begin
            exp = 32'h100 + 32'(i);
            checks++;
            if (fired_nonce[i] !== exp) begin
                errors++;
                $display("FAIL stop_seq: idx=%0d nonce=%h expected %h", i, fired_nonce[i], exp);
            end
        end
        checks++;
        if (cd != exp_cd) begin
            errors++;
            $display("FAIL stop_done_cycle: done at %0d expected %0d", cd, exp_cd);
        end
        drain_report(1'b1, 32'h102);
    endtask

    task automatic test_backpressure();
        int n;
        int cd;
        logic [31:0] exp;
        submit(32'h40, 32'd8, 32'h1234_5678);
        run_job(32'h1234_5678, 1, 64'h0, 1'b1, 20, 80, n, cd);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL bp_count: issued=%0d expected 8", n);
        end
        for (int i = 0; i < n && i < 8; i++) begin
            exp = 32'h40 + 32'(i);
            checks++;
            if (fired_nonce[i] !== exp) begin
                errors++;
                $display("FAIL bp_seq: idx=%0d nonce=%h expected %h", i, fired_nonce[i], exp);
            end
        end
        checks++;
        if (n >= 5 && fired_cyc[4] != 22) begin
            errors++;
            $display("FAIL bp_fifth_issue: cycle=%0d expected 22", fired_cyc[4]);
        end
        checks++;
        if (cd != 30) begin
            errors++;
            $display("FAIL bp_done_cycle: done at %0d expected 30", cd);
        end
        drain_report(1'b0, 32'h0);
    endtask

    task automatic test_wrap_zero();
        int n;
        int cd;
        logic [31:0] exp_seq [0:2];
        exp_seq[0] = 32'hFFFF_FFFE;
        exp_seq[1] = 32'hFFFF_FFFF;
        exp_seq[2] = 32'h0000_0000;
        // Hits on results 1 and 2: only the first one may be recorded.
        submit(32'hFFFF_FFFE, 32'd3, 32'h0000_0100);
        run_job(32'h0000_0100, 2, 64'h6, 1'b0, 0, 40, n, cd);
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL wrap_count: issued=%0d expected 3", n);
        end
        for (int i = 0; i < n && i < 3; i++) begin
            checks++;
            if (fired_nonce[i] !== exp_seq[i]) begin
                errors++;
                $display("FAIL wrap_seq: idx=%0d nonce=%h expected %h", i, fired_nonce[i], exp_seq[i]);
            end
        end
        checks++;
        if (cd != 5) begin
            errors++;
            $display("FAIL wrap_done_cycle: done at %0d expected 5", cd);
        end
        drain_report(1'b1, 32'hFFFF_FFFF);

        submit(32'h77, 32'd0, 32'h5);
        run_job(32'h5, 1, 64'h0, 1'b0, 0, 10, n, cd);
        checks++;
        if (n != 0 || cd != 0) begin
            errors++;
            $display("FAIL zero_count: issued=%0d done at %0d expected 0 0", n, cd);
        end
        drain_report(1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_job();
        int n;
        int cd;
        submit(32'h500, 32'd10, 32'hAAAA_5555);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            job_v_i = 1'b0;
            ready_i = 1'b1;
            #1;
            checks++;
            if (v_o !== 1'b1 || nonce_o !== 32'h500 + 32'(i)) begin
                errors++;
                $display("FAIL midjob_issue: idx=%0d v_o=%b nonce_o=%h expected 1 %h", i, v_o, nonce_o, 32'h500 + 32'(i));
            end
        end
        @(negedge clk);
        reset_i = 1'b0;
        ready_i = 1'b0;
        #1;
        checks++;
        if (job_ready_o !== 1'b1 || v_o !== 1'b0 || done_v_o !== 1'b0 || found_o !== 1'b0) begin
            errors++;
            $display("FAIL midjob_reset_flags: ready=%b v=%b done=%b found=%b expected 1 0 0 0", job_ready_o, v_o, done_v_o, found_o);
        end
        checks++;
        if (nonce_o !== 32'h0 || target_o !== 32'h0 || nonce_found_o !== 32'h0) begin
            errors++;
            $display("FAIL midjob_reset_values: nonce=%h target=%h nonce_found=%h expected 0 0 0", nonce_o, target_o, nonce_found_o);
        end
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        v_i    = 1'b1;
        data_i = 1'b1;
        #1;
        checks++;
        if (yumi_o !== 1'b1) begin
            errors++;
            $display("FAIL stale_yumi: yumi_o=%b expected 1", yumi_o);
        end
        $display("stale result hit=1 presented");
        @(negedge clk);
        v_i    = 1'b0;
        data_i = 1'b0;
        #1;
        checks++;
        if (found_o !== 1'b0 || nonce_found_o !== 32'h0 || done_v_o !== 1'b0 || job_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL stale_ignored: found=%b nonce_found=%h done=%b ready=%b expected 0 0 0 1", found_o, nonce_found_o, done_v_o, job_ready_o);
        end

        submit(32'h20, 32'd3, 32'h0BAD_F00D);
        run_job(32'h0BAD_F00D, 2, 64'h2, 1'b0, 0, 40, n, cd);
        checks++;
        if (n != 3 || cd != 5) begin
            errors++;
            $display("FAIL post_reset_job: issued=%0d done at %0d expected 3 5", n, cd);
        end
        drain_report(1'b1, 32'h21);
    endtask

    initial begin
        test_reset();
        test_full_range();
        test_early_stop();
        test_backpressure();
        test_wrap_zero();
        test_reset_mid_job();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
